// File: rtl/log_hdr_mem_ctrl.sv
// rtl/log_hdr_mem_ctrl.sv - log-header store responder with arbitration, response hold and clearing sweep
//
// Purpose: owns the per-slot log header RAM (single port, one access per cycle).
//   Serves commit-engine reads and writes plus prepare-engine writes, and clears
//   every slot after reset before it accepts any request.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   commit_log_hdr_mem_rd_req_*       read request (val/addr), rdy back
//   log_hdr_mem_commit_rd_resp_*      read response (val/data), rdy from commit engine
//   commit_log_hdr_mem_wr_*           commit write (val/addr/data), rdy back
//   prep_log_hdr_mem_wr_*             prepare write (val/addr/data), rdy back
//   log_hdr_mem_init_done             clearing sweep finished (sticky until reset)
module log_hdr_mem_ctrl #(
  parameter int LOG_DEPTH_W = 6,
  parameter int HDR_W       = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   commit_log_hdr_mem_rd_req_val,
  input  logic [LOG_DEPTH_W-1:0] commit_log_hdr_mem_rd_req_addr,
  output logic                   log_hdr_mem_commit_rd_req_rdy,
  output logic                   log_hdr_mem_commit_rd_resp_val,
  output logic [HDR_W-1:0]       log_hdr_mem_commit_rd_resp_data,
  input  logic                   commit_log_hdr_mem_rd_resp_rdy,
  input  logic                   commit_log_hdr_mem_wr_val,
  input  logic [LOG_DEPTH_W-1:0] commit_log_hdr_mem_wr_addr,
  input  logic [HDR_W-1:0]       commit_log_hdr_mem_wr_data,
  output logic                   log_hdr_mem_commit_wr_rdy,
  input  logic                   prep_log_hdr_mem_wr_val,
  input  logic [LOG_DEPTH_W-1:0] prep_log_hdr_mem_wr_addr,
  input  logic [HDR_W-1:0]       prep_log_hdr_mem_wr_data,
  output logic                   log_hdr_mem_prep_wr_rdy,
  output logic                   log_hdr_mem_init_done
);

  localparam int DEPTH = 1 << LOG_DEPTH_W;

  typedef enum logic [1:0] {INIT, IDLE, RD_PEND, RD_HOLD} state_t;

  state_t                 state, state_nxt;
  logic [LOG_DEPTH_W-1:0] clr_idx;
  logic                   rd_starved;
  logic                   init_done_q;
  logic [HDR_W-1:0]       hold_q;
  logic [HDR_W-1:0]       ram_q;
  logic [HDR_W-1:0]       mem [DEPTH];

  logic                   mem_we;
  logic                   mem_re;
  logic [LOG_DEPTH_W-1:0] mem_addr;
  logic [HDR_W-1:0]       mem_wdata;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (clr_idx == '1) state_nxt = IDLE;
      IDLE:    if (log_hdr_mem_commit_rd_req_rdy) state_nxt = RD_PEND;
      RD_PEND: state_nxt = commit_log_hdr_mem_rd_resp_rdy ? IDLE : RD_HOLD;
      RD_HOLD: if (commit_log_hdr_mem_rd_resp_rdy) state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  // Output / arbitration logic. The commit write always wins; between the
  // prepare write and a read the prepare write wins unless the read has
  // already lost once (rd_starved), which bounds read wait to one cycle.
  always_comb begin
    log_hdr_mem_commit_rd_req_rdy   = 1'b0;
    log_hdr_mem_commit_rd_resp_val  = 1'b0;
    log_hdr_mem_commit_rd_resp_data = '0;
    log_hdr_mem_commit_wr_rdy       = 1'b0;
    log_hdr_mem_prep_wr_rdy         = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      INIT: begin
        mem_we   = 1'b1;
        mem_addr = clr_idx;
      end
      IDLE: begin
        log_hdr_mem_commit_wr_rdy = commit_log_hdr_mem_wr_val;
        log_hdr_mem_prep_wr_rdy   = prep_log_hdr_mem_wr_val && !commit_log_hdr_mem_wr_val &&
                                    !(commit_log_hdr_mem_rd_req_val && rd_starved);
        log_hdr_mem_commit_rd_req_rdy = commit_log_hdr_mem_rd_req_val && !commit_log_hdr_mem_wr_val &&
                                        !log_hdr_mem_prep_wr_rdy;
      end
      RD_PEND, RD_HOLD: begin
        log_hdr_mem_commit_wr_rdy = commit_log_hdr_mem_wr_val;
        log_hdr_mem_prep_wr_rdy   = prep_log_hdr_mem_wr_val && !commit_log_hdr_mem_wr_val;
        log_hdr_mem_commit_rd_resp_val  = 1'b1;
        log_hdr_mem_commit_rd_resp_data = (state == RD_PEND) ? ram_q : hold_q;
      end
      default: ;
    endcase
    if (log_hdr_mem_commit_wr_rdy) begin
      mem_we    = 1'b1;
      mem_addr  = commit_log_hdr_mem_wr_addr;
      mem_wdata = commit_log_hdr_mem_wr_data;
    end else if (log_hdr_mem_prep_wr_rdy) begin
      mem_we    = 1'b1;
      mem_addr  = prep_log_hdr_mem_wr_addr;
      mem_wdata = prep_log_hdr_mem_wr_data;
    end else if (log_hdr_mem_commit_rd_req_rdy) begin
      mem_re   = 1'b1;
      mem_addr = commit_log_hdr_mem_rd_req_addr;
    end
  end

  // Control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_idx     <= '0;
      rd_starved  <= 1'b0;
      init_done_q <= 1'b0;
      hold_q      <= '0;
    end else begin
      if (state == INIT) clr_idx <= clr_idx + 1'b1;
      if (state == INIT && clr_idx == '1) init_done_q <= 1'b1;
      if (log_hdr_mem_commit_rd_req_rdy)
        rd_starved <= 1'b0;
      else if (state == IDLE && commit_log_hdr_mem_rd_req_val && log_hdr_mem_prep_wr_rdy)
        rd_starved <= 1'b1;
      // The RAM output register stays untouched until the next read, but the
      // hold copy makes the held response independent of the RAM entirely.
      if (state == RD_PEND && !commit_log_hdr_mem_rd_resp_rdy) hold_q <= ram_q;
    end
  end

  // Single-ported storage with registered read data
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) ram_q <= mem[mem_addr];
  end

  assign log_hdr_mem_init_done = init_done_q;

endmodule

// File: tb/tb_log_hdr_mem_ctrl.sv
// tb/tb_log_hdr_mem_ctrl.sv - self-checking bench for log_hdr_mem_ctrl
module tb_log_hdr_mem_ctrl;
  localparam int AW    = 6;
  localparam int DW    = 64;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_val, rd_rdy, resp_val, resp_rdy;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] resp_data;
  logic          c_val, c_rdy, p_val, p_rdy, init_done;
  logic [AW-1:0] c_addr, p_addr;
  logic [DW-1:0] c_data, p_data;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model [DEPTH];

  log_hdr_mem_ctrl #(.LOG_DEPTH_W(AW), .HDR_W(DW)) dut (
    .clk                             (clk),
    .rst                             (rst),
    .commit_log_hdr_mem_rd_req_val   (rd_val),
    .commit_log_hdr_mem_rd_req_addr  (rd_addr),
    .log_hdr_mem_commit_rd_req_rdy   (rd_rdy),
    .log_hdr_mem_commit_rd_resp_val  (resp_val),
    .log_hdr_mem_commit_rd_resp_data (resp_data),
    .commit_log_hdr_mem_rd_resp_rdy  (resp_rdy),
    .commit_log_hdr_mem_wr_val       (c_val),
    .commit_log_hdr_mem_wr_addr      (c_addr),
    .commit_log_hdr_mem_wr_data      (c_data),
    .log_hdr_mem_commit_wr_rdy       (c_rdy),
    .prep_log_hdr_mem_wr_val         (p_val),
    .prep_log_hdr_mem_wr_addr        (p_addr),
    .prep_log_hdr_mem_wr_data        (p_data),
    .log_hdr_mem_prep_wr_rdy         (p_rdy),
    .log_hdr_mem_init_done           (init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    rd_val = 1'b0; resp_rdy = 1'b0; c_val = 1'b0; p_val = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Starts at a negedge with rst high; releases rst and checks the full sweep,
  // then that a read of rd_slot is accepted in the very first post-sweep cycle.
  task automatic sweep_check(input logic [AW-1:0] rd_slot);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    rd_val = 1'b1; c_val = 1'b1; p_val = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk("init_quiet", 64'({rd_rdy, c_rdy, p_rdy, init_done, resp_val}), 64'd0);
      @(negedge clk);
    end
    idle_inputs();
    rd_val = 1'b1; rd_addr = rd_slot;
    #1;
    chk("init_done_rise", 64'(init_done), 64'd1);
    chk("first_rd_accept", 64'(rd_rdy), 64'd1);
    @(negedge clk);
    rd_val = 1'b0; resp_rdy = 1'b1;
    #1;
    chk("first_rd_val", 64'(resp_val), 64'd1);
    chk("first_rd_data", resp_data, 64'd0);
    @(negedge clk);
    resp_rdy = 1'b0;
  endtask

  // Starts and ends at a negedge. port 0 = commit, 1 = prepare.
  task automatic do_wr(input int port, input logic [AW-1:0] a, input logic [DW-1:0] d, output int waited);
    int n = 0;
    if (port == 0) begin c_val = 1'b1; c_addr = a; c_data = d; end
    else           begin p_val = 1'b1; p_addr = a; p_data = d; end
    #1;
    while (!(port == 0 ? c_rdy : p_rdy) && n < 10) begin @(negedge clk); #1; n++; end
    chk(port == 0 ? "c_wr_accept" : "p_wr_accept", 64'(port == 0 ? c_rdy : p_rdy), 64'd1);
    model[a] = d;
    waited = n;
    @(negedge clk);
    c_val = 1'b0; p_val = 1'b0;
  endtask

  // Starts and ends at a negedge; holds resp_rdy low for holdc cycles.
  task automatic do_read(input logic [AW-1:0] a, input int holdc, output int waited);
    logic [DW-1:0] exp;
    int n = 0;
    rd_val = 1'b1; rd_addr = a; resp_rdy = 1'b0;
    #1;
    while (!rd_rdy && n < 10) begin @(negedge clk); #1; n++; end
    chk("rd_accept", 64'(rd_rdy), 64'd1);
    exp = model[a];
    waited = n;
    @(negedge clk);
    rd_val = 1'b0; resp_rdy = (holdc == 0);
    #1;
    chk("rd_resp_val", 64'(resp_val), 64'd1);
    chk("rd_resp_data", resp_data, exp);
    for (int h = 0; h < holdc; h++) begin
      @(negedge clk);
      resp_rdy = (h == holdc - 1);
      #1;
      chk("rd_hold_val", 64'(resp_val), 64'd1);
      chk("rd_hold_data", resp_data, exp);
    end
    @(negedge clk);
    resp_rdy = 1'b0;
    #1;
    chk("rd_resp_drop", 64'(resp_val), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    int w, last_rd, nrd;
    logic pending;
    logic [DW-1:0] exp_pend, exp5;

    // Reset values with every request valid
    rst = 1'b1; resp_rdy = 1'b1;
    rd_val = 1'b1; rd_addr = '0; c_val = 1'b1; c_addr = '0; c_data = '1;
    p_val = 1'b1; p_addr = '0; p_data = '1;
    #1;
    chk("reset_outputs", 64'({rd_rdy, c_rdy, p_rdy, init_done, resp_val}), 64'd0);
    chk("reset_data", resp_data, 64'd0);
    @(negedge clk); @(negedge clk);
    sweep_check(6'd63);

    // Prep write slot 5, read it the very next cycle
    do_wr(1, 6'd5, 64'hA5A5, w);
    chk("p_wr_nowait", 64'(w), 64'd0);
    do_read(6'd5, 0, w);
    chk("raw_rd_nowait", 64'(w), 64'd0);

    // Held response unaffected by a commit write to the same slot
    rd_val = 1'b1; rd_addr = 6'd5; resp_rdy = 1'b0;
    #1; chk("hold_rd_accept", 64'(rd_rdy), 64'd1);
    exp5 = model[5];
    @(negedge clk);
    rd_val = 1'b0; c_val = 1'b1; c_addr = 6'd5; c_data = 64'h1;
    #1;
    chk("hold_c_wr_accept", 64'(c_rdy), 64'd1);
    chk("hold_pend_data", resp_data, exp5);
    model[5] = 64'h1;
    @(negedge clk);
    c_val = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_val", 64'(resp_val), 64'd1);
      chk("hold_data", resp_data, exp5);
      @(negedge clk);
    end
    resp_rdy = 1'b1;
    #1; chk("hold_take_data", resp_data, exp5);
    @(negedge clk);
    resp_rdy = 1'b0;
    #1; chk("hold_drop", 64'(resp_val), 64'd0);
    @(negedge clk);
    do_read(6'd5, 0, w);

    // Continuous prep writes against continuous reads
    last_rd = -1; nrd = 0; pending = 1'b0; exp_pend = '0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      p_val = 1'b1; p_addr = 6'($urandom_range(0, 15)); p_data = rnd64();
      rd_val = 1'b1; rd_addr = 6'($urandom_range(0, 15)); resp_rdy = 1'b1;
      #1;
      if (pending) begin
        chk("alt_resp_val", 64'(resp_val), 64'd1);
        chk("alt_resp_data", resp_data, exp_pend);
        pending = 1'b0;
      end
      chk("alt_one_winner", 64'(p_rdy ^ rd_rdy), 64'd1);
      if (p_rdy) model[p_addr] = p_data;
      if (rd_rdy) begin
        exp_pend = model[rd_addr];
        pending = 1'b1;
        if (last_rd >= 0) chk("alt_rd_gap", 64'(cyc - last_rd), 64'd3);
        last_rd = cyc;
        nrd++;
      end
      @(negedge clk);
    end
    idle_inputs();
    resp_rdy = 1'b1;
    #1;
    if (pending) chk("alt_last_resp", resp_data, exp_pend);
    chk("alt_read_count", 64'(nrd), 64'd8);
    @(negedge clk);
    resp_rdy = 1'b0;

    // Same-cycle commit and prep writes to slot 9
    c_val = 1'b1; c_addr = 6'd9; c_data = 64'h11;
    p_val = 1'b1; p_addr = 6'd9; p_data = 64'h22;
    #1;
    chk("same_slot_c_first", 64'({c_rdy, p_rdy}), 64'b10);
    @(negedge clk);
    c_val = 1'b0;
    #1;
    chk("same_slot_p_next", 64'(p_rdy), 64'd1);
    @(negedge clk);
    p_val = 1'b0;
    model[9] = 64'h22;
    do_read(6'd9, 0, w);

    // Randomized mix of writes and reads on a small slot range
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: do_wr(0, 6'($urandom_range(0, 15)), rnd64(), w);
        1: do_wr(1, 6'($urandom_range(0, 15)), rnd64(), w);
        default: do_read(6'($urandom_range(0, 15)), int'($urandom_range(0, 2)), w);
      endcase
    end

    // Reset while a response is held
    rd_val = 1'b1; rd_addr = 6'd9; resp_rdy = 1'b0;
    #1; chk("rst_rd_accept", 64'(rd_rdy), 64'd1);
    @(negedge clk);
    rd_val = 1'b0;
    @(negedge clk);
    #1; chk("rst_pre_hold_val", 64'(resp_val), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_resp_val_drop", 64'(resp_val), 64'd0);
    chk("rst_resp_data_zero", resp_data, 64'd0);
    @(negedge clk);
    sweep_check(6'd9);
    do_read(6'd5, 0, w);
    do_read(6'd9, 1, w);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
